// File: rtl/audio_level_detector.sv
// Audio ADC capture and windowed peak/clap detector for the audio_codec read side.
// Optional per-channel DC blocker enabled by defining AUDIO_LEVEL_DC_BLOCK_EN.
module audio_level_detector #(
   parameter int unsigned WINDOW      = 4800,
   parameter logic [23:0] THRESH      = 24'd2000000,
   parameter int unsigned HOLDOFF_WIN = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        read_ready,
   output logic        read,
   input  logic [23:0] readdata_left,
   input  logic [23:0] readdata_right,
   output logic [23:0] peak,
   output logic        peak_valid,
   output logic        clap
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LISTEN,
      S_ABS,
      S_ACCUM,
      S_REPORT
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [23:0] r_left;
   logic [23:0] r_right;
   logic [23:0] r_mag;
   logic [23:0] r_win_peak;
   logic [23:0] r_peak;
   logic [15:0] r_cnt;
   logic [7:0]  r_holdoff;

   logic        w_last;
   logic        w_clap;
   logic [23:0] w_acc_max;
   logic [23:0] w_mag_l;
   logic [23:0] w_mag_r;

   // |x| with the most negative code folded onto full-scale positive
   function automatic logic [23:0] abs_sat(input logic [23:0] x);
      if (x == 24'h800000)
         return 24'h7FFFFF;
      else if (x[23])
         return -x;
      else
         return x;
   endfunction

`ifdef AUDIO_LEVEL_DC_BLOCK_EN
   logic [23:0] r_avg_l;
   logic [23:0] r_avg_r;
   logic [24:0] w_diff_l;
   logic [24:0] w_diff_r;

   function automatic logic [23:0] sat24(input logic [24:0] d);
      if (d[24] != d[23])
         return d[24] ? 24'h800000 : 24'h7FFFFF;
      else
         return d[23:0];
   endfunction

   assign w_diff_l = {r_left[23], r_left} - {r_avg_l[23], r_avg_l};
   assign w_diff_r = {r_right[23], r_right} - {r_avg_r[23], r_avg_r};
   assign w_mag_l  = abs_sat(sat24(w_diff_l));
   assign w_mag_r  = abs_sat(sat24(w_diff_r));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_avg_l <= '0;
         r_avg_r <= '0;
      end else if (r_state == S_ABS) begin
         r_avg_l <= r_avg_l + 24'($signed(w_diff_l) >>> 8);
         r_avg_r <= r_avg_r + 24'($signed(w_diff_r) >>> 8);
      end
   end
`else
   assign w_mag_l = abs_sat(r_left);
   assign w_mag_r = abs_sat(r_right);
`endif

   assign w_last    = (r_cnt == 16'(WINDOW - 1));
   assign w_acc_max = (r_mag > r_win_peak) ? r_mag : r_win_peak;
   assign w_clap    = (r_peak >= THRESH) && (r_holdoff == '0);
   assign peak      = r_peak;

   always_comb begin
      w_next     = r_state;
      read       = 1'b0;
      peak_valid = 1'b0;
      clap       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable)
               w_next = S_LISTEN;
         end
         S_LISTEN: begin
            read = read_ready;
            if (read_ready)
               w_next = S_ABS;
            else if (!enable)
               w_next = S_IDLE;
         end
         S_ABS:   w_next = S_ACCUM;
         S_ACCUM: w_next = w_last ? S_REPORT : S_LISTEN;
         S_REPORT: begin
            peak_valid = 1'b1;
            clap       = w_clap;
            w_next     = enable ? S_LISTEN : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_left     <= '0;
         r_right    <= '0;
         r_mag      <= '0;
         r_win_peak <= '0;
         r_peak     <= '0;
         r_cnt      <= '0;
         r_holdoff  <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_LISTEN: begin
               if (read_ready) begin
                  r_left  <= readdata_left;
                  r_right <= readdata_right;
               end else if (!enable) begin
                  // abandoning a partial window; last reported peak is kept
                  r_win_peak <= '0;
                  r_cnt      <= '0;
               end
            end
            S_ABS: begin
               r_mag <= (w_mag_l > w_mag_r) ? w_mag_l : w_mag_r;
            end
            S_ACCUM: begin
               if (w_last) begin
                  r_peak     <= w_acc_max;
                  r_win_peak <= '0;
                  r_cnt      <= '0;
               end else begin
                  r_win_peak <= w_acc_max;
                  r_cnt      <= r_cnt + 16'd1;
               end
            end
            S_REPORT: begin
               if (w_clap)
                  r_holdoff <= 8'(HOLDOFF_WIN);
               else if (r_holdoff != '0)
                  r_holdoff <= r_holdoff - 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
